// File: rtl/kd_tree_pkg.sv
// Shared KD-tree types and default geometry, common to the query controller and the tree instance.
package kd_tree_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_LOAD,
    ST_QUERY,
    ST_DRAIN
  } state_t;

  localparam int KD_NUM_NODES    = 127;
  localparam int KD_TREE_LATENCY = 7;

endpackage

// File: rtl/leaf_result_fifo.sv
// Synchronous result FIFO. Data is visible one cycle after the push and is never bypassed.
// A push is accepted when full only together with a pop. A pop is ignored when empty.
module leaf_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, do_push, do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/kd_tree_query_ctrl.sv
// Loads KD-tree split words, then streams query patches and collects the leaf indices.
// Results appear TREE_LATENCY+1 cycles after issue. Issue is held off while in-flight plus queued results would overflow the result FIFO.
module kd_tree_query_ctrl
  import kd_tree_pkg::*;
#(
  parameter int INTERNAL_WIDTH = 22,
  parameter int PATCH_WIDTH    = 55,
  parameter int ADDRESS_WIDTH  = 8,
  parameter int NUM_NODES      = KD_NUM_NODES,
  parameter int TREE_LATENCY   = KD_TREE_LATENCY,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      load_en,
  input  logic [15:0]               num_patches,
  output logic                      busy,
  output logic                      done,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [INTERNAL_WIDTH-1:0] cfg_data,
  input  logic                      patch_valid,
  output logic                      patch_ready,
  input  logic [PATCH_WIDTH-1:0]    patch_data,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [ADDRESS_WIDTH-1:0]  res_index,
  output logic                      tree_rst_n,
  output logic                      tree_fsm_enable,
  output logic                      tree_sender_enable,
  output logic [INTERNAL_WIDTH-1:0] tree_sender_data,
  output logic [PATCH_WIDTH-1:0]    tree_patch_in,
  input  logic [ADDRESS_WIDTH-1:0]  tree_leaf_index
);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int NW = $clog2(NUM_NODES+1);
  localparam int LW = $clog2(TREE_LATENCY+1);

  state_t              state;
  logic [15:0]         num_q, issued, retired;
  logic [NW-1:0]       node_cnt;
  logic [TREE_LATENCY-1:0] vld_sr;
  logic [LW-1:0]       inflight;
  logic [CW-1:0]       fifo_count;
  logic [16:0]         credit_used;
  logic                fifo_empty, fifo_push, fifo_pop, cfg_hs, patch_hs;

  assign busy               = (state != ST_IDLE);
  assign cfg_ready          = (state == ST_LOAD);
  assign cfg_hs             = cfg_valid & cfg_ready;
  assign tree_fsm_enable    = cfg_hs;
  assign tree_sender_enable = cfg_hs;
  assign tree_sender_data   = cfg_hs ? cfg_data : '0;
  assign tree_rst_n         = ~rst & (state != ST_CLR);

  // Credits cover both results still in the tree and results already queued.
  assign credit_used   = 17'(inflight) + 17'(fifo_count);
  assign patch_ready   = (state == ST_QUERY) & (issued < num_q) & (credit_used < 17'(FIFO_DEPTH));
  assign patch_hs      = patch_valid & patch_ready;
  assign tree_patch_in = patch_hs ? patch_data : '0;

  assign fifo_push = vld_sr[TREE_LATENCY-1];
  assign res_valid = ~fifo_empty;
  assign fifo_pop  = res_valid & res_ready;

  leaf_result_fifo #(
    .WIDTH (ADDRESS_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (tree_leaf_index),
    .dout  (res_index),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      done     <= 1'b0;
      num_q    <= '0;
      issued   <= '0;
      retired  <= '0;
      node_cnt <= '0;
      vld_sr   <= '0;
      inflight <= '0;
    end else begin
      done     <= 1'b0;
      vld_sr   <= (vld_sr << 1) | TREE_LATENCY'(patch_hs);
      inflight <= inflight + LW'(patch_hs) - LW'(fifo_push);
      if (fifo_push) retired <= retired + 16'd1;
      if (patch_hs)  issued  <= issued + 16'd1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            num_q    <= num_patches;
            issued   <= '0;
            retired  <= '0;
            node_cnt <= '0;
            if (load_en)                 state <= ST_CLR;
            else if (num_patches != '0)  state <= ST_QUERY;
            else                         done  <= 1'b1;
          end
        end
        ST_CLR: state <= ST_LOAD;
        ST_LOAD: begin
          if (cfg_hs) begin
            node_cnt <= node_cnt + NW'(1);
            if (node_cnt == NW'(NUM_NODES-1)) begin
              if (num_q == '0) begin
                state <= ST_IDLE;
                done  <= 1'b1;
              end else begin
                state <= ST_QUERY;
              end
            end
          end
        end
        ST_QUERY: begin
          if (patch_hs && (issued == num_q - 16'd1)) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if ((inflight == '0) && (fifo_count == '0) && (retired == num_q)) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
